// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: a chain of one-bit full adders feeding a single
// output register stage with carry-out, signed overflow and zero flags.

module ripple_carry_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);
    localparam int STAGES = 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic [STAGES:0]  vld_pipe;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ripple_carry_adder_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_comb[i]),
            .co (carry[i+1])
        );
    end

    assign vld_pipe[0] = in_valid;

    // Result registers only load on a valid sample; they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum         <= '0;
            cout        <= 1'b0;
            ovf         <= 1'b0;
            zero        <= 1'b1;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                sum  <= sum_comb;
                cout <= carry[WIDTH];
                ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
                zero <= ~|sum_comb;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder: expected results are queued at issue
// and popped by an independent monitor whenever out_valid is seen.

module tb_ripple_carry_adder;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout, ovf, zero, out_valid;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad = 0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: unsigned sum for sum/cout, signed range test for ovf.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t e;
        int   full, sa, sb, ss;
        full = int'(ta) + int'(tb) + int'(tc);
        sa = (int'(ta) >= (1 << (W-1))) ? int'(ta) - (1 << W) : int'(ta);
        sb = (int'(tb) >= (1 << (W-1))) ? int'(tb) - (1 << W) : int'(tb);
        ss = sa + sb + int'(tc);
        e.sum  = W'(full % (1 << W));
        e.cout = (full >= (1 << W));
        e.ovf  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
        e.zero = (full % (1 << W)) == 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic tc);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; a = ta; b = tb; cin = tc;
        if (v && !r) begin
            last_exp = model(ta, tb, tc);
            q.push_back(last_exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%h cout=%b with empty queue", sum, cout);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'({sum, cout, ovf, zero}), 32'(e));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset with a valid operand present: it must be discarded.
        drive(1'b1, 1'b1, 4'hF, 4'h1, 1'b1);
        drive(1'b1, 1'b1, 4'h7, 4'h7, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check_reset_state("reset");

        drive(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        drive(1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
        drive(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
        drive(1'b0, 1'b1, 4'b1010, 4'b0101, 1'b1);
        drive(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
        drive(1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0);
        drive(1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        check("hold_outputs", 32'({sum, cout, ovf, zero}), 32'(last_exp));
        check("hold_out_valid", 32'(out_valid), 32'd0);
        check("hold_all_ones", 32'({sum, cout}), 32'({4'b1111, 1'b1}));

        // Reset in the middle of a stream.
        drive(1'b0, 1'b1, 4'h3, 4'h4, 1'b0);
        drive(1'b1, 1'b1, 4'h9, 4'h9, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        check_reset_state("midreset");

        for (int i = 0; i < 2000; i++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ripple_carry_adder.md
RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and sum width in bits, legal range 1..64.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a, b and cin are sampled this cycle.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-008 The block SHALL have port sum, output, WIDTH bits: registered sum bits.
REQ-009 The block SHALL have port cout, output, 1 bit: registered carry out of bit WIDTH-1.
REQ-010 The block SHALL have port ovf, output, 1 bit: registered two's-complement overflow flag.
REQ-011 The block SHALL have port zero, output, 1 bit: registered flag, high when sum is all zeros.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the outputs hold a new result this cycle.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin exactly, with WIDTH+1 bit result and no saturation.
REQ-014 The block SHALL build the datapath as a chain of WIDTH one-bit full adders: s_i = a_i^b_i^c_i, c_(i+1) = a_i&b_i | c_i&(a_i^b_i), c_0 = cin, cout = c_WIDTH.
REQ-015 The block SHALL set ovf = c_WIDTH ^ c_(WIDTH-1), which equals 1 when signed a+b+cin does not fit in WIDTH bits.
REQ-016 The block SHALL set zero to 1 if and only if the sum bits are all 0, regardless of cout.
REQ-017 Latency SHALL be exactly 1 cycle: when in_valid=1 at edge N, sum, cout, ovf and zero SHALL show that result after edge N, and out_valid SHALL be 1 for that cycle.
REQ-018 When in_valid=0 at an edge, sum, cout, ovf and zero SHALL keep their previous values, and out_valid SHALL go to 0 after that edge.
REQ-019 Back-to-back in_valid=1 SHALL produce one result per cycle with no bubbles, and out_valid SHALL stay 1.
REQ-020 The block SHALL have no backpressure: results are never stalled or dropped.
REQ-021 The outputs SHALL be fully defined for any a, b and cin, including all-ones + all-ones + 1, which gives sum = all ones and cout = 1.

Reset
REQ-022 When rst=1 at a rising edge, sum, cout, ovf and out_valid SHALL become 0 and zero SHALL become 1, matching the value of the reset sum.
REQ-023 rst SHALL take priority over in_valid: an operand sampled in a reset cycle SHALL be discarded.
REQ-024 On the first edge after rst deasserts, the block SHALL accept input normally.
REQ-025 A reset in the middle of a stream SHALL cancel the pending result, so out_valid=0 on the next cycle.

Verification (WIDTH=4, in_valid=1, result checked one cycle later)
REQ-026 a=0000, b=0000, cin=0 -> sum=0000, cout=0, ovf=0, zero=1.
REQ-027 a=0101, b=0011, cin=0 -> sum=1000, cout=0, ovf=1, zero=0.
REQ-028 a=1111, b=0001, cin=0 -> sum=0000, cout=1, ovf=0, zero=1.
REQ-029 a=1010, b=0101, cin=1 -> sum=0000, cout=1, ovf=0, zero=1.
REQ-030 a=1111, b=1111, cin=1 -> sum=1111, cout=1, ovf=0, zero=0; then in_valid=0 -> outputs hold, out_valid=0.
REQ-031 Assert rst while valid inputs are streaming -> all outputs are at reset values on the next cycle, and no result appears for the reset-cycle operand; after that, 2000 random vectors match a+b+cin.
